// File: rtl/forward_scoreboard.sv
// Operand forwarding with per-register in-flight write scoreboard for NUM_SRC sources over NUM_BYP bypass channels.
// Latency: data/depends/stall are combinational; scoreboard updates are visible one cycle after issue/retire.
// Backpressure: stall holds issue on an unready bypass hit, a pending write, or a saturated destination counter.
module forward_scoreboard #(
   parameter int XLEN     = 32,
   parameter int REG_BITS = 5,
   parameter int NUM_SRC  = 2,
   parameter int NUM_BYP  = 3,
   parameter int CNT_BITS = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [NUM_SRC*REG_BITS-1:0]  src,
   output logic [NUM_SRC*XLEN-1:0]      data,
   output logic [NUM_SRC-1:0]           depends,
   output logic                         stall,
   input  logic                         issue_valid,
   input  logic                         issue_writes,
   input  logic [REG_BITS-1:0]          issue_dest,
   input  logic [NUM_BYP-1:0]           byp_valid,
   input  logic [NUM_BYP-1:0]           byp_ready,
   input  logic [NUM_BYP*REG_BITS-1:0]  byp_dest,
   input  logic [NUM_BYP*XLEN-1:0]      byp_data,
   input  logic                         retire_valid,
   input  logic [REG_BITS-1:0]          retire_dest,
   output logic [31:0]                  stall_cycles
);

   localparam int NUM_REGS = 2**REG_BITS;
   localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

   logic [CNT_BITS-1:0] pend [NUM_REGS];
   logic [NUM_SRC-1:0]  slot_stall;
   logic [REG_BITS-1:0] sel;
   logic                hit;
   logic                dest_full;
   logic                inc;
   logic                dec;

   // Per-slot resolution: r0 is constant zero, youngest matching channel wins, then the scoreboard.
   always_comb begin
      data       = '0;
      depends    = '0;
      slot_stall = '0;
      sel        = '0;
      hit        = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         sel = src[k*REG_BITS +: REG_BITS];
         hit = 1'b0;
         if (sel != '0) begin
            for (int i = 0; i < NUM_BYP; i++) begin
               if (!hit && byp_valid[i] && (byp_dest[i*REG_BITS +: REG_BITS] == sel)) begin
                  hit        = 1'b1;
                  depends[k] = 1'b1;
                  if (byp_ready[i])
                     data[k*XLEN +: XLEN] = byp_data[i*XLEN +: XLEN];
                  else
                     slot_stall[k] = 1'b1;
               end
            end
            if (!hit && (pend[sel] != '0)) begin
               depends[k]    = 1'b1;
               slot_stall[k] = 1'b1;
            end
         end
      end
   end

   // Issue stall: any slot waiting, or the destination counter cannot take another in-flight write.
   always_comb begin
      dest_full = issue_valid && issue_writes && (issue_dest != '0) && (pend[issue_dest] == CNT_MAX);
      stall     = (|slot_stall) || dest_full;
      inc       = issue_valid && issue_writes && !stall && (issue_dest != '0);
      dec       = retire_valid && (retire_dest != '0);
   end

   // Pending-write counters: an issue and retire to the same register cancel out; retire never underflows.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int r = 0; r < NUM_REGS; r++)
            pend[r] <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (inc && (issue_dest == REG_BITS'(r)) && !(dec && (retire_dest == REG_BITS'(r))))
               pend[r] <= pend[r] + CNT_BITS'(1);
            else if (dec && (retire_dest == REG_BITS'(r)) && !(inc && (issue_dest == REG_BITS'(r)))
                     && (pend[r] != '0))
               pend[r] <= pend[r] - CNT_BITS'(1);
         end
      end
   end

   // Retiring a register with nothing in flight means the pipeline lost track of a write.
   always_ff @(posedge clk) begin
      if (!rst && !flush && dec && !(inc && (issue_dest == retire_dest)))
         assert (pend[retire_dest] != '0)
            else $error("forward_scoreboard: retire of r%0d with no pending write", retire_dest);
   end

   // Saturating count of stalled cycles; survives flush, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: bypass priority, scoreboard stalls, counter limits, flush.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
// Expected values are hand-computed constants per vector.
module tb_forward_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [9:0]  src;
   logic [63:0] data;
   logic [1:0]  depends;
   logic        stall;
   logic        issue_valid;
   logic        issue_writes;
   logic [4:0]  issue_dest;
   logic [2:0]  byp_valid;
   logic [2:0]  byp_ready;
   logic [14:0] byp_dest;
   logic [95:0] byp_data;
   logic        retire_valid;
   logic [4:0]  retire_dest;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_pass   = 0;

   forward_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .src          (src),
      .data         (data),
      .depends      (depends),
      .stall        (stall),
      .issue_valid  (issue_valid),
      .issue_writes (issue_writes),
      .issue_dest   (issue_dest),
      .byp_valid    (byp_valid),
      .byp_ready    (byp_ready),
      .byp_dest     (byp_dest),
      .byp_data     (byp_data),
      .retire_valid (retire_valid),
      .retire_dest  (retire_dest),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance past the next rising edge; inputs may change afterwards.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush        = 1'b0;
      src          = '0;
      issue_valid  = 1'b0;
      issue_writes = 1'b0;
      issue_dest   = '0;
      byp_valid    = '0;
      byp_ready    = '0;
      byp_dest     = '0;
      byp_data     = '0;
      retire_valid = 1'b0;
      retire_dest  = '0;
   endtask

   task automatic issue(input logic [4:0] d);
      issue_valid  = 1'b1;
      issue_writes = 1'b1;
      issue_dest   = d;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      src = {5'd5, 5'd0};
      tick();
      rst = 1'b0;
      #1;
      // Reset state
      check("rst_data",    data,         64'h0);
      check("rst_depends", depends,      2'b00);
      check("rst_stall",   stall,        1'b0);
      check("rst_scyc",    stall_cycles, 32'd0);

      // Youngest of two ready channels with the same dest wins
      tick(); idle();
      byp_valid = 3'b011; byp_ready = 3'b111;
      byp_dest  = {5'd0, 5'd7, 5'd7};
      byp_data  = {32'h0, 32'h22, 32'h11};
      src       = {5'd0, 5'd7};
      #1;
      check("prio_data",    data,    {32'h0, 32'h11});
      check("prio_depends", depends, 2'b01);
      check("prio_stall",   stall,   1'b0);

      // Bypass on register 0 is ignored
      byp_valid = 3'b001; byp_dest = {5'd0, 5'd0, 5'd0}; byp_data = {32'h0, 32'h0, 32'h55};
      src = {5'd0, 5'd0};
      #1;
      check("r0_data",    data,    64'h0);
      check("r0_depends", depends, 2'b00);

      // Unready young channel blocks an older ready one
      tick(); idle();
      byp_valid = 3'b101; byp_ready = 3'b100;
      byp_dest  = {5'd3, 5'd0, 5'd3};
      byp_data  = {32'hAA, 32'h0, 32'h0};
      src       = {5'd3, 5'd0};
      #1;
      check("unrdy_stall",   stall,        1'b1);
      check("unrdy_data",    data,         64'h0);
      check("unrdy_depends", depends,      2'b10);
      check("unrdy_scyc0",   stall_cycles, 32'd0);
      tick(); idle();
      #1;
      check("unrdy_scyc1",   stall_cycles, 32'd1);
      check("idle_stall",    stall,        1'b0);

      // Multi-cycle op to r9: scoreboard stalls until retire
      issue(5'd9);
      tick(); idle();
      tick();
      src = {5'd0, 5'd9};
      #1;
      check("mul_stall",   stall,   1'b1);
      check("mul_depends", depends, 2'b01);
      byp_valid = 3'b010; byp_ready = 3'b010;
      byp_dest  = {5'd0, 5'd9, 5'd0};
      byp_data  = {32'h0, 32'h99, 32'h0};
      #1;
      check("mul_byp_data",  data,  {32'h0, 32'h99});
      check("mul_byp_stall", stall, 1'b0);
      byp_valid = '0;
      retire_valid = 1'b1; retire_dest = 5'd9;
      #1;
      check("mul_ret_stall", stall, 1'b1);
      tick(); idle();
      src = {5'd0, 5'd9};
      #1;
      check("mul_done_stall",   stall,        1'b0);
      check("mul_done_depends", depends,      2'b00);
      check("mul_done_scyc",    stall_cycles, 32'd2);

      // Counter limit on r4
      issue(5'd4); tick();
      issue(5'd4); tick();
      issue(5'd4); tick();
      issue(5'd4);
      #1;
      check("full_stall", stall, 1'b1);
      tick(); idle();
      #1;
      check("full_scyc", stall_cycles, 32'd3);
      retire_valid = 1'b1; retire_dest = 5'd4;    // count 3 -> 2
      tick(); idle();
      issue(5'd4); retire_valid = 1'b1; retire_dest = 5'd4;
      #1;
      check("pair_stall", stall, 1'b0);           // count stays 2
      tick(); idle();
      issue(5'd4);
      #1;
      check("refill_stall", stall, 1'b0);         // 2 -> 3
      tick(); idle();
      issue(5'd4);
      #1;
      check("refull_stall", stall, 1'b1);
      idle();
      #1;

      // Flush clears pending writes and drops a same-cycle issue
      issue(5'd6); tick();
      issue(5'd6); tick(); idle();
      src = {5'd0, 5'd6};
      #1;
      check("pre_flush_stall", stall, 1'b1);
      src = '0;
      flush = 1'b1;
      issue(5'd6);
      tick(); idle();
      src = {5'd0, 5'd6};
      #1;
      check("flush_stall",   stall,        1'b0);
      check("flush_depends", depends,      2'b00);
      check("flush_scyc",    stall_cycles, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
